// File: rtl/sm_imem_loader.sv
// sm_imem_loader: runtime program loader writing a framed byte stream into a node's instruction RAM
//
// Frame: 0xA5, node (NODE_ID or 0xFF), count_lo, count_hi, then count little-endian 32-bit words.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid      byte stream input; in_ready low only during the word write cycle
//   mem_we/addr/wdata     registered instruction RAM write port (word addressed)
//   core_rst_n            holds the core in reset until a full image for this node is written
//   load_done             a complete image has been written
//   load_err              sticky: last addressed frame was larger than SIZE words
//   busy                  loader is inside a frame
module sm_imem_loader #(
    parameter int SIZE    = 128,
    parameter int NODE_ID = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_rst_n,
    output logic        load_done,
    output logic        load_err,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, NODE, LEN_LO, LEN_HI, DATA, WRITE, SKIP} state_t;

    localparam logic [15:0] SZ  = 16'(SIZE);
    localparam logic [7:0]  NID = 8'(NODE_ID);

    state_t      state;
    logic        match;
    logic [15:0] cnt;
    logic [17:0] bcnt;
    logic [15:0] widx;
    logic [1:0]  bsel;
    logic [31:0] asm_w;
    logic [15:0] hdr_cnt;

    assign hdr_cnt  = {in_data, cnt[7:0]};
    assign in_ready = state != WRITE;
    assign busy     = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            match      <= 1'b0;
            cnt        <= '0;
            bcnt       <= '0;
            widx       <= '0;
            bsel       <= '0;
            asm_w      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (state == WRITE) begin
                widx <= widx + 16'd1;
                if (widx + 16'd1 == cnt) begin
                    state      <= IDLE;
                    load_done  <= 1'b1;
                    core_rst_n <= 1'b1;
                end else begin
                    state <= DATA;
                end
            end else if (in_valid) begin
                case (state)
                    IDLE:   state <= in_data == 8'hA5 ? NODE : IDLE;
                    NODE: begin
                        match <= in_data == NID || in_data == 8'hFF;
                        state <= LEN_LO;
                    end
                    LEN_LO: begin
                        cnt[7:0] <= in_data;
                        state    <= LEN_HI;
                    end
                    LEN_HI: begin
                        cnt  <= hdr_cnt;
                        bcnt <= {hdr_cnt, 2'b00};
                        if (!match) begin
                            state <= hdr_cnt == 16'd0 ? IDLE : SKIP;
                        end else if (hdr_cnt > SZ) begin
                            // oversize image: drain it without touching the RAM or the core state
                            load_err <= 1'b1;
                            state    <= SKIP;
                        end else begin
                            load_err   <= 1'b0;
                            widx       <= '0;
                            bsel       <= '0;
                            load_done  <= hdr_cnt == 16'd0;
                            core_rst_n <= hdr_cnt == 16'd0;
                            state      <= hdr_cnt == 16'd0 ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        // shift right so the first byte of the word ends up in bits 7:0
                        asm_w <= {in_data, asm_w[31:8]};
                        bsel  <= bsel + 2'd1;
                        if (bsel == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {16'd0, widx};
                            mem_wdata <= {in_data, asm_w[31:8]};
                            state     <= WRITE;
                        end
                    end
                    SKIP: begin
                        bcnt  <= bcnt - 18'd1;
                        state <= bcnt == 18'd1 ? IDLE : SKIP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
